// File: rtl/sram_1p_ctrl.sv
// sram_1p_ctrl: valid/ready front end for a 1-port SRAM macro with active-low
// strobes. Sweeps INIT_VAL into the array after reset. Hides the macro's
// one-cycle read latency behind a 2-entry response FIFO whose occupancy plus
// the in-flight read is capped at two, so read data is never dropped.
module sram_1p_ctrl #(
  parameter int                DATA_W   = 144,
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 3,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_CEB,
  output logic              sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic              inflight_reg;   // a read was issued last cycle; Q is valid now
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [ADDR_W-1:0] a_hold_reg;     // last address driven, kept while idle
  logic [DATA_W-1:0] d_hold_reg;     // last write data driven, kept while idle

  logic       in_run;
  logic       resp_pop;
  logic       read_ok;
  logic       access;
  logic [1:0] credit;

  assign in_run     = (state_reg == ST_RUN);
  assign init_done  = in_run;
  assign resp_valid = (count_reg != 2'd0);
  assign resp_rdata = fifo_mem[rd_ptr_reg];

  // Handshake: reads need a free slot (FIFO + in-flight), or a slot freed by a pop this cycle
  always_comb begin
    resp_pop  = resp_valid && resp_ready;
    credit    = count_reg + {1'b0, inflight_reg};
    read_ok   = (credit < 2'd2) || ((credit == 2'd2) && resp_pop);
    req_ready = RSTB && in_run && (req_write || read_ok);
    access    = req_valid && req_ready;
  end

  // Macro strobes: sweep during INIT, pass accepted requests through in RUN, park otherwise
  always_comb begin
    sram_CEB = 1'b1;
    sram_WEB = 1'b1;
    sram_A   = a_hold_reg;
    sram_D   = d_hold_reg;
    if (RSTB) begin
      if (!in_run) begin
        sram_CEB = 1'b0;
        sram_WEB = 1'b0;
        sram_A   = init_cnt_reg;
        sram_D   = INIT_VAL;
      end else if (access) begin
        sram_CEB = 1'b0;
        sram_WEB = !req_write;
        sram_A   = req_addr;
        sram_D   = req_wdata;
      end
    end
  end

  // Control FSM: INIT walks init_cnt over every word, then RUN forever
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_reg    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_reg <= '0;
    end else if (state_reg == ST_INIT) begin
      init_cnt_reg <= init_cnt_reg + 1'b1;
      if (init_cnt_reg == ADDR_W'(DEPTH - 1)) begin
        state_reg <= ST_RUN;
      end
    end
  end

  // Read pipeline: mark the in-flight read, capture Q only on the cycle after it, pop on handshake
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      inflight_reg <= access && !req_write;
      if (inflight_reg) begin
        fifo_mem[wr_ptr_reg] <= sram_Q;
        wr_ptr_reg           <= !wr_ptr_reg;
      end
      if (resp_pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, resp_pop};
    end
  end

  // Remember the last driven A/D so idle cycles do not toggle the macro pins
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      a_hold_reg <= '0;
      d_hold_reg <= '0;
    end else if (!in_run) begin
      a_hold_reg <= init_cnt_reg;
      d_hold_reg <= INIT_VAL;
    end else if (access) begin
      a_hold_reg <= req_addr;
      d_hold_reg <= req_wdata;
    end
  end

endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Self-checking bench for sram_1p_ctrl: a behavioural 1-port macro, a
// reference memory plus an expected-response queue with due cycles, and
// directed phases followed by a randomized phase.
module tb_sram_1p_ctrl;

  localparam int DW    = 144;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RSTB;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          sram_CEB, sram_WEB;
  logic [AW-1:0] sram_A;
  logic [DW-1:0] sram_D, sram_Q;

  // second instance without the init sweep
  logic          req_valid0, req_ready0, req_write0;
  logic [AW-1:0] req_addr0;
  logic [DW-1:0] req_wdata0;
  logic          resp_valid0, resp_ready0;
  logic [DW-1:0] resp_rdata0;
  logic          init_done0;
  logic          sram_CEB0, sram_WEB0;
  logic [AW-1:0] sram_A0;
  logic [DW-1:0] sram_D0, sram_Q0;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] smem [DEPTH];

  sram_1p_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_EN(1'b1), .INIT_VAL('0)) u_dut (
    .CLK(CLK), .RSTB(RSTB),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_CEB(sram_CEB), .sram_WEB(sram_WEB), .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q)
  );

  sram_1p_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .INIT_EN(1'b0), .INIT_VAL('0)) u_dut0 (
    .CLK(CLK), .RSTB(RSTB),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
    .init_done(init_done0),
    .sram_CEB(sram_CEB0), .sram_WEB(sram_WEB0), .sram_A(sram_A0), .sram_D(sram_D0), .sram_Q(sram_Q0)
  );

  assign sram_Q0 = '0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // behavioural macro: Q is garbage except on the cycle after a read
  always @(posedge CLK) begin
    if (!sram_CEB && !sram_WEB) smem[sram_A] <= sram_D;
    if (!sram_CEB && sram_WEB) sram_Q <= smem[sram_A];
    else sram_Q <= rnd_data();
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0b expected=%0b (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic rst_chk();
    chk1("rst req_ready", req_ready, 1'b0);
    chk1("rst resp_valid", resp_valid, 1'b0);
    chkd("rst resp_rdata", resp_rdata, '0);
    chk1("rst init_done", init_done, 1'b0);
    chk1("rst sram_CEB", sram_CEB, 1'b1);
    chk1("rst sram_WEB", sram_WEB, 1'b1);
    chkn("rst sram_A", int'(sram_A), 0);
    chkd("rst sram_D", sram_D, '0);
  endtask

  // called just after a posedge with RSTB high; checks n sweep cycles
  task automatic init_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk1("init CEB", sram_CEB, 1'b0);
      chk1("init WEB", sram_WEB, 1'b0);
      chkn("init A", int'(sram_A), i);
      chkd("init D", sram_D, '0);
      chk1("init init_done", init_done, 1'b0);
      chk1("init req_ready", req_ready, 1'b0);
      if (i == 0) begin
        chk1("noinit init_done", init_done0, 1'b1);
        chk1("noinit req_ready", req_ready0, 1'b1);
        chk1("noinit CEB idle", sram_CEB0, 1'b1);
      end
      @(posedge CLK); #1;
    end
    if (n == DEPTH) begin
      @(negedge CLK);
      chk1("post-init init_done", init_done, 1'b1);
      chk1("post-init req_ready", req_ready, 1'b1);
      chk1("post-init CEB idle", sram_CEB, 1'b1);
      @(posedge CLK); #1;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    end
  endtask

  // one RUN cycle against the reference model; called just after a posedge
  task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rr, output logic acc);
    logic ev, pop, er;
    int   t;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
    @(negedge CLK);
    t  = cyc;
    ev = (q.size() > 0) && (q[0].due <= t);
    chk1("resp_valid", resp_valid, ev);
    if (ev) chkd("resp_rdata", resp_rdata, q[0].data);
    pop = ev && rr;
    er  = w || (q.size() < 2) || ((q.size() == 2) && pop);
    chk1("req_ready", req_ready, er);
    acc = v && er;
    chk1("sram_CEB", sram_CEB, !acc);
    if (acc) begin
      chk1("sram_WEB", sram_WEB, !w);
      chkn("sram_A", int'(sram_A), int'(a));
      if (w) chkd("sram_D", sram_D, d);
    end
    $display("cyc %0d v=%0b w=%0b a=%0d rr=%0b acc=%0b resp=%0b", t, v, w, a, rr, acc, ev);
    @(posedge CLK);
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (w) ref_mem[a] = d;
      else q.push_back('{ref_mem[a], t + 2});
    end
    #1;
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) step(1'b1, w, a, d, 1'b1, acc);
    chk1("request accepted in time", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   nacc;
    RSTB = 1'b0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 1;
    req_valid0 = 0; req_write0 = 0; req_addr0 = '0; req_wdata0 = '0; resp_ready0 = 1;
    repeat (2) @(posedge CLK);
    #1;
    rst_chk();
    chk1("noinit rst init_done", init_done0, 1'b1);
    chk1("noinit rst req_ready", req_ready0, 1'b0);
    RSTB = 1'b1;
    init_sweep(DEPTH);

    // INIT_EN=0 instance accepts a write straight away
    req_valid0 = 1; req_write0 = 1; req_addr0 = 3'd2; req_wdata0 = 144'h5;
    #2;
    chk1("noinit write CEB", sram_CEB0, 1'b0);
    chk1("noinit write WEB", sram_WEB0, 1'b0);
    chkn("noinit write A", int'(sram_A0), 2);
    @(posedge CLK); #1;
    req_valid0 = 0;

    // write then immediate read-back, plus an unwritten word
    do_req(1'b1, 3'd3, 144'hA5);
    do_req(1'b0, 3'd3, '0);
    do_req(1'b0, 3'd5, '0);
    idle(3);

    // preload value=addr, then 8 back-to-back reads
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, AW'(i), DW'(i));
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, AW'(i), '0);
    idle(3);

    // backpressure: 4 reads offered with resp_ready low, only 2 fit
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, AW'(i), '0, 1'b0, acc);
      if (acc) nacc++;
    end
    chkn("stalled reads accepted", nacc, 2);
    step(1'b1, 1'b1, 3'd6, 144'h66, 1'b0, acc);
    chk1("write during stall", acc, 1'b1);
    do_req(1'b0, 3'd2, '0);
    do_req(1'b0, 3'd3, '0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      step(1'(($urandom % 4) != 0), 1'($urandom % 2), AW'($urandom % DEPTH),
           rnd_data(), 1'(($urandom % 3) != 0), acc);
    end
    idle(4);

    // reset in the middle of the sweep
    req_valid = 0;
    RSTB = 1'b0; q.delete();
    #1;
    rst_chk();
    @(posedge CLK); #1;
    RSTB = 1'b1;
    init_sweep(4);
    RSTB = 1'b0;
    #1;
    rst_chk();
    @(posedge CLK); #1;
    RSTB = 1'b1;
    init_sweep(DEPTH);

    // reset with a read in flight
    do_req(1'b1, 3'd1, 144'h77);
    do_req(1'b0, 3'd1, '0);
    req_valid = 0;
    RSTB = 1'b0; q.delete();
    #1;
    rst_chk();
    @(posedge CLK); #1;
    RSTB = 1'b1;
    init_sweep(DEPTH);
    idle(3);
    do_req(1'b0, 3'd1, '0);
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
